// File: rtl/delay_sweep_ctrl.sv
// Delay-tap sweep over the native port (EN_VTC off, step delays with dwell, EN_VTC on); `SWEEP_READBACK_EN adds a per-step read.
// Latency: one transaction in flight, completion >= 2 cycles after EN; stalls on M_NATIVE_READY, times out after TIMEOUT_CYCLES.
module delay_sweep_ctrl #(
    parameter int NATIVE_ADDR_WDITH = 2,
    parameter int NATIVE_DATA_WIDTH = 32,
    parameter int DELAY_WIDTH       = 9,
    parameter int DWELL_WIDTH       = 16,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                         NATIVE_CLK,
    input  logic                         rst,
    input  logic                         sweep_start,
    input  logic                         sweep_abort,
    input  logic [DELAY_WIDTH-1:0]       cfg_start,
    input  logic [DELAY_WIDTH-1:0]       cfg_stop,
    input  logic [DELAY_WIDTH-1:0]       cfg_step,
    input  logic [DWELL_WIDTH-1:0]       cfg_dwell,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic                         step_valid,
    output logic [DELAY_WIDTH-1:0]       step_delay,
    output logic                         M_NATIVE_EN,
    output logic                         M_NATIVE_WR,
    output logic [NATIVE_ADDR_WDITH-1:0] M_NATIVE_ADDR,
    output logic [NATIVE_DATA_WIDTH-1:0] M_NATIVE_DATA_IN,
    input  logic [NATIVE_DATA_WIDTH-1:0] M_NATIVE_DATA_OUT,
    input  logic                         M_NATIVE_READY
);

    localparam int TW = (TIMEOUT_CYCLES < 3) ? 2 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] RDY_MIN = TW'(2);
    localparam logic [NATIVE_ADDR_WDITH-1:0] ADDR_DELAY = NATIVE_ADDR_WDITH'(0);
    localparam logic [NATIVE_ADDR_WDITH-1:0] ADDR_VTC   = NATIVE_ADDR_WDITH'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_VTC_OFF,
        S_SET,
        S_DWELL,
        S_READ,
        S_NEXT,
        S_VTC_ON,
        S_DONE,
        S_WAIT
    } state_t;

`ifdef SWEEP_READBACK_EN
    localparam state_t AFTER_DWELL = S_READ;
`else
    localparam state_t AFTER_DWELL = S_NEXT;
`endif

    state_t                         state_q, state_d;
    state_t                         ret_q, ret_d;
    logic                           abort_q, abort_d;
    logic                           error_q, error_d;
    logic [DELAY_WIDTH-1:0]         cur_q, cur_d;
    logic [DELAY_WIDTH-1:0]         stop_q, stop_d;
    logic [DELAY_WIDTH-1:0]         step_q, step_d;
    logic [DWELL_WIDTH-1:0]         dwell_q, dwell_d;
    logic [DWELL_WIDTH-1:0]         dcnt_q, dcnt_d;
    logic [TW-1:0]                  tcnt_q, tcnt_d;
    logic [DELAY_WIDTH-1:0]         step_delay_q, step_delay_d;
    logic                           txn_wr_q, txn_wr_d;
    logic [NATIVE_ADDR_WDITH-1:0]   txn_addr_q, txn_addr_d;
    logic [NATIVE_DATA_WIDTH-1:0]   txn_data_q, txn_data_d;

    logic                           issue;
    logic                           iss_wr;
    logic [NATIVE_ADDR_WDITH-1:0]   iss_addr;
    logic [NATIVE_DATA_WIDTH-1:0]   iss_data;
    logic                           abort_any;
    logic [DELAY_WIDTH:0]           sum_w;
    logic                           unused_rd;

    assign abort_any = abort_q | sweep_abort;
    // One bit of headroom so a step past the top of the delay range cannot wrap back below cfg_stop.
    assign sum_w     = {1'b0, cur_q} + {1'b0, step_q};
    assign unused_rd = ^M_NATIVE_DATA_OUT;

    always_ff @(posedge NATIVE_CLK) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge NATIVE_CLK) begin
        if (rst) begin
            ret_q        <= S_IDLE;
            abort_q      <= 1'b0;
            error_q      <= 1'b0;
            cur_q        <= '0;
            stop_q       <= '0;
            step_q       <= '0;
            dwell_q      <= '0;
            dcnt_q       <= '0;
            tcnt_q       <= '0;
            step_delay_q <= '0;
            txn_wr_q     <= 1'b0;
            txn_addr_q   <= '0;
            txn_data_q   <= '0;
        end else begin
            ret_q        <= ret_d;
            abort_q      <= abort_d;
            error_q      <= error_d;
            cur_q        <= cur_d;
            stop_q       <= stop_d;
            step_q       <= step_d;
            dwell_q      <= dwell_d;
            dcnt_q       <= dcnt_d;
            tcnt_q       <= tcnt_d;
            step_delay_q <= step_delay_d;
            txn_wr_q     <= txn_wr_d;
            txn_addr_q   <= txn_addr_d;
            txn_data_q   <= txn_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        abort_d      = abort_q;
        error_d      = error_q;
        cur_d        = cur_q;
        stop_d       = stop_q;
        step_d       = step_q;
        dwell_d      = dwell_q;
        dcnt_d       = dcnt_q;
        tcnt_d       = tcnt_q;
        step_delay_d = step_delay_q;
        txn_wr_d     = txn_wr_q;
        txn_addr_d   = txn_addr_q;
        txn_data_d   = txn_data_q;

        if (busy && sweep_abort) begin
            abort_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (sweep_start) begin
                    cur_d   = cfg_start;
                    stop_d  = cfg_stop;
                    step_d  = (cfg_step == '0) ? DELAY_WIDTH'(1) : cfg_step;
                    dwell_d = cfg_dwell;
                    error_d = 1'b0;
                    abort_d = 1'b0;
                    if (cfg_start > cfg_stop) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_VTC_OFF;
                    end
                end
            end
            S_VTC_OFF, S_SET, S_READ, S_VTC_ON: begin
                txn_wr_d   = iss_wr;
                txn_addr_d = iss_addr;
                txn_data_d = iss_data;
                tcnt_d     = TW'(1);
                state_d    = S_WAIT;
                case (state_q)
                    S_VTC_OFF: ret_d = S_SET;
                    S_SET:     ret_d = (dwell_q == '0) ? AFTER_DWELL : S_DWELL;
                    S_READ:    ret_d = S_NEXT;
                    default:   ret_d = S_DONE;
                endcase
            end
            S_WAIT: begin
                if ((tcnt_q >= RDY_MIN) && M_NATIVE_READY) begin
                    dcnt_d  = DWELL_WIDTH'(1);
                    state_d = (abort_any && (ret_q != S_DONE)) ? S_VTC_ON : ret_q;
`ifdef SWEEP_READBACK_EN
                    if (ret_q == S_NEXT) begin
                        step_delay_d = M_NATIVE_DATA_OUT[DELAY_WIDTH-1:0];
                    end
`endif
                end else if (tcnt_q >= TO_MAX) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_DWELL: begin
                if (abort_any) begin
                    state_d = S_VTC_ON;
                end else if (dcnt_q >= dwell_q) begin
                    state_d = AFTER_DWELL;
                end else begin
                    dcnt_d = dcnt_q + DWELL_WIDTH'(1);
                end
            end
            S_NEXT: begin
                if (abort_any || (sum_w > {1'b0, stop_q})) begin
                    state_d = S_VTC_ON;
                end else begin
                    cur_d   = sum_w[DELAY_WIDTH-1:0];
                    state_d = S_SET;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifndef SWEEP_READBACK_EN
        if ((state_d == S_NEXT) && (state_q != S_NEXT)) begin
            step_delay_d = cur_q;
        end
`endif
    end

    // WR/ADDR/DATA come straight from the state in the EN cycle and from the held copy until completion.
    always_comb begin
        busy       = (state_q != S_IDLE) && (state_q != S_DONE);
        done       = (state_q == S_DONE);
        error      = error_q;
        step_valid = (state_q == S_NEXT) && !abort_any;
        step_delay = step_delay_q;
        issue      = 1'b0;
        iss_wr     = 1'b0;
        iss_addr   = '0;
        iss_data   = '0;
        case (state_q)
            S_VTC_OFF: begin
                issue    = 1'b1;
                iss_wr   = 1'b1;
                iss_addr = ADDR_VTC;
                iss_data = '0;
            end
            S_SET: begin
                issue    = 1'b1;
                iss_wr   = 1'b1;
                iss_addr = ADDR_DELAY;
                iss_data = NATIVE_DATA_WIDTH'(cur_q);
            end
            S_READ: begin
                issue    = 1'b1;
                iss_wr   = 1'b0;
                iss_addr = ADDR_DELAY;
            end
            S_VTC_ON: begin
                issue    = 1'b1;
                iss_wr   = 1'b1;
                iss_addr = ADDR_VTC;
                iss_data = NATIVE_DATA_WIDTH'(1);
            end
            default: begin
                issue = 1'b0;
            end
        endcase
        M_NATIVE_EN      = issue;
        M_NATIVE_WR      = issue ? iss_wr   : txn_wr_q;
        M_NATIVE_ADDR    = issue ? iss_addr : txn_addr_q;
        M_NATIVE_DATA_IN = issue ? iss_data : txn_data_q;
    end

endmodule

// File: tb/tb_delay_sweep_ctrl.sv
// Directed bench for delay_sweep_ctrl with a native target answering READY 3 cycles after EN.
module tb_delay_sweep_ctrl;

`ifdef SWEEP_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        sweep_start;
    logic        sweep_abort;
    logic [8:0]  cfg_start;
    logic [8:0]  cfg_stop;
    logic [8:0]  cfg_step;
    logic [15:0] cfg_dwell;
    logic        busy;
    logic        done;
    logic        error;
    logic        step_valid;
    logic [8:0]  step_delay;
    logic        M_NATIVE_EN;
    logic        M_NATIVE_WR;
    logic [1:0]  M_NATIVE_ADDR;
    logic [31:0] M_NATIVE_DATA_IN;
    logic [31:0] M_NATIVE_DATA_OUT;
    logic        M_NATIVE_READY = 1'b0;

    always #5 clk = ~clk;

    assign M_NATIVE_DATA_OUT = 32'h0000_01FF;

    delay_sweep_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .NATIVE_CLK        (clk),
        .rst               (rst),
        .sweep_start       (sweep_start),
        .sweep_abort       (sweep_abort),
        .cfg_start         (cfg_start),
        .cfg_stop          (cfg_stop),
        .cfg_step          (cfg_step),
        .cfg_dwell         (cfg_dwell),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .step_valid        (step_valid),
        .step_delay        (step_delay),
        .M_NATIVE_EN       (M_NATIVE_EN),
        .M_NATIVE_WR       (M_NATIVE_WR),
        .M_NATIVE_ADDR     (M_NATIVE_ADDR),
        .M_NATIVE_DATA_IN  (M_NATIVE_DATA_IN),
        .M_NATIVE_DATA_OUT (M_NATIVE_DATA_OUT),
        .M_NATIVE_READY    (M_NATIVE_READY)
    );

    logic [34:0] wq[$];
    logic [8:0]  sq[$];
    int done_cnt = 0;
    int en_cnt = 0;
    int cyc = 0;
    int last_en_cyc = 0;
    int last_done_cyc = 0;
    int mctr = 0;
    bit stuck = 1'b0;
    int n_cmp = 0;
    int n_fail = 0;

    // Target model and monitor, on the falling edge.
    always @(negedge clk) begin
        cyc++;
        M_NATIVE_READY = 1'b0;
        if (M_NATIVE_EN) begin
            wq.push_back({M_NATIVE_WR, M_NATIVE_ADDR, M_NATIVE_DATA_IN});
            en_cnt++;
            last_en_cyc = cyc;
            mctr = 1;
        end else if (mctr != 0) begin
            if (mctr == 3) begin
                M_NATIVE_READY = !stuck;
                mctr = 0;
            end else begin
                mctr++;
            end
        end
        if (step_valid) sq.push_back(step_delay);
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_sweep(input logic [8:0] s, input logic [8:0] e, input logic [8:0] st,
                               input logic [15:0] dw, input logic ab);
        cfg_start   = s;
        cfg_stop    = e;
        cfg_step    = st;
        cfg_dwell   = dw;
        sweep_start = 1'b1;
        sweep_abort = ab;
        tick();
        sweep_start = 1'b0;
        sweep_abort = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != d0) break;
            tick();
        end
        if (done_cnt != d0) ok = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sweep_start = 1'b0;
        sweep_abort = 1'b0;
        cfg_start = '0;
        cfg_stop = '0;
        cfg_step = '0;
        cfg_dwell = '0;
        repeat (3) tick();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", error); end
        n_cmp++; if (step_valid !== 1'b0) begin n_fail++; $display("FAIL reset_step_valid: got %b want 0", step_valid); end
        n_cmp++; if (M_NATIVE_EN !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b want 0", M_NATIVE_EN); end
        n_cmp++; if ({M_NATIVE_WR, M_NATIVE_ADDR, M_NATIVE_DATA_IN} !== 35'd0) begin
            n_fail++; $display("FAIL reset_bus: got %h want 0", {M_NATIVE_WR, M_NATIVE_ADDR, M_NATIVE_DATA_IN});
        end
        n_cmp++; if (step_delay !== 9'd0) begin n_fail++; $display("FAIL reset_step_delay: got %h want 0", step_delay); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_sweep();
        int w0, s0, d0;
        bit ok;
        logic [34:0] wr_seen[$];
        logic [34:0] exp_w[5];
        logic [8:0]  exp_s[3];
        exp_w[0] = {1'b1, 2'd1, 32'd0};
        exp_w[1] = {1'b1, 2'd0, 32'd10};
        exp_w[2] = {1'b1, 2'd0, 32'd15};
        exp_w[3] = {1'b1, 2'd0, 32'd20};
        exp_w[4] = {1'b1, 2'd1, 32'd1};
        exp_s[0] = RB ? 9'h1FF : 9'd10;
        exp_s[1] = RB ? 9'h1FF : 9'd15;
        exp_s[2] = RB ? 9'h1FF : 9'd20;
        w0 = wq.size(); s0 = sq.size(); d0 = done_cnt;
        start_sweep(9'd10, 9'd20, 9'd5, 16'd4, 1'b0);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise: got %b want 1", busy); end
        repeat (3) tick();
        // A second start while busy must not disturb the running sweep.
        start_sweep(9'd0, 9'd1, 9'd1, 16'd0, 1'b0);
        wait_done(d0, 3000, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL basic_done_wait: got no done want done"); end
        tick();
        for (int i = w0; i < wq.size(); i++) if (wq[i][34]) wr_seen.push_back(wq[i]);
        n_cmp++; if (wr_seen.size() != 5) begin n_fail++; $display("FAIL basic_write_count: got %0d want 5", wr_seen.size()); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (i >= wr_seen.size() || wr_seen[i] !== exp_w[i]) begin
                n_fail++; $display("FAIL basic_write_%0d: got %h want %h", i, (i < wr_seen.size()) ? wr_seen[i] : 35'h0, exp_w[i]);
            end
        end
        n_cmp++; if (sq.size() - s0 != 3) begin n_fail++; $display("FAIL basic_step_count: got %0d want 3", sq.size() - s0); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (s0 + i >= sq.size() || sq[s0 + i] !== exp_s[i]) begin
                n_fail++; $display("FAIL basic_step_%0d: got %h want %h", i, (s0 + i < sq.size()) ? sq[s0 + i] : 9'h0, exp_s[i]);
            end
        end
        n_cmp++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL basic_error: got %b want 0", error); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall: got %b want 0", busy); end
    endtask

    task automatic test_single_step();
        int w0, s0, d0;
        bit ok;
        logic [34:0] wr_seen[$];
        w0 = wq.size(); s0 = sq.size(); d0 = done_cnt;
        // Abort in the same cycle as start is ignored.
        start_sweep(9'd7, 9'd7, 9'd0, 16'd2, 1'b1);
        wait_done(d0, 1000, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_done_wait: got no done want done"); end
        tick();
        for (int i = w0; i < wq.size(); i++) if (wq[i][34]) wr_seen.push_back(wq[i]);
        n_cmp++; if (wr_seen.size() != 3) begin n_fail++; $display("FAIL single_write_count: got %0d want 3", wr_seen.size()); end
        n_cmp++; if (wr_seen.size() < 2 || wr_seen[1] !== {1'b1, 2'd0, 32'd7}) begin
            n_fail++; $display("FAIL single_set_write: got %h want %h", (wr_seen.size() > 1) ? wr_seen[1] : 35'h0, {1'b1, 2'd0, 32'd7});
        end
        n_cmp++; if (sq.size() - s0 != 1) begin n_fail++; $display("FAIL single_step_count: got %0d want 1", sq.size() - s0); end
        n_cmp++; if (sq.size() <= s0 || sq[s0] !== (RB ? 9'h1FF : 9'd7)) begin
            n_fail++; $display("FAIL single_step_delay: got %h want %h", (sq.size() > s0) ? sq[s0] : 9'h0, RB ? 9'h1FF : 9'd7);
        end
        n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL single_error: got %b want 0", error); end
    endtask

    task automatic test_bad_cfg();
        int e0, d0;
        bit ok;
        e0 = en_cnt; d0 = done_cnt;
        start_sweep(9'd20, 9'd10, 9'd1, 16'd0, 1'b0);
        wait_done(d0, 3, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL badcfg_done_within_3: got no done want done"); end
        n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL badcfg_error: got %b want 1", error); end
        repeat (5) tick();
        n_cmp++; if (en_cnt != e0) begin n_fail++; $display("FAIL badcfg_no_en: got %0d want 0", en_cnt - e0); end
        n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL badcfg_error_sticky: got %b want 1", error); end
    endtask

    task automatic test_timeout();
        int e0, d0;
        bit ok;
        e0 = en_cnt; d0 = done_cnt;
        stuck = 1'b1;
        start_sweep(9'd0, 9'd4, 9'd1, 16'd0, 1'b0);
        n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL timeout_error_cleared: got %b want 0", error); end
        wait_done(d0, 600, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL timeout_done_wait: got no done want done"); end
        n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL timeout_error: got %b want 1", error); end
        n_cmp++; if (last_done_cyc - last_en_cyc != TIMEOUT + 1) begin
            n_fail++; $display("FAIL timeout_latency: got %0d want %0d", last_done_cyc - last_en_cyc, TIMEOUT + 1);
        end
        repeat (20) tick();
        n_cmp++; if (en_cnt - e0 != 1) begin n_fail++; $display("FAIL timeout_en_count: got %0d want 1", en_cnt - e0); end
        stuck = 1'b0;
    endtask

    task automatic test_abort();
        int w0, s0, d0, tgt, nw;
        bit ok;
        w0 = wq.size(); s0 = sq.size(); d0 = done_cnt;
        tgt = RB ? 5 : 4;
        start_sweep(9'd10, 9'd20, 9'd5, 16'd8, 1'b0);
        n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL abort_error_cleared: got %b want 0", error); end
        for (int i = 0; i < 300; i++) begin
            if (wq.size() >= w0 + tgt - 1) break;
            tick();
        end
        n_cmp++; if (wq.size() < w0 + tgt - 1) begin n_fail++; $display("FAIL abort_second_set_wait: got %0d want %0d", wq.size() - w0, tgt - 1); end
        // Second SET issued this cycle; completion after 3 cycles, then DWELL.
        repeat (5) tick();
        sweep_abort = 1'b1;
        tick();
        sweep_abort = 1'b0;
        wait_done(d0, 300, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL abort_done_wait: got no done want done"); end
        tick();
        nw = wq.size() - w0;
        n_cmp++; if (nw != tgt) begin n_fail++; $display("FAIL abort_txn_count: got %0d want %0d", nw, tgt); end
        n_cmp++; if (wq.size() == 0 || wq[wq.size() - 1] !== {1'b1, 2'd1, 32'd1}) begin
            n_fail++; $display("FAIL abort_last_txn: got %h want %h", (wq.size() > 0) ? wq[wq.size() - 1] : 35'h0, {1'b1, 2'd1, 32'd1});
        end
        n_cmp++; if (sq.size() - s0 != 1) begin n_fail++; $display("FAIL abort_step_count: got %0d want 1", sq.size() - s0); end
        n_cmp++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL abort_done_count: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL abort_error: got %b want 0", error); end
    endtask

    task automatic test_readback();
        int e0, s0, d0;
        bit ok;
        e0 = en_cnt; s0 = sq.size(); d0 = done_cnt;
        start_sweep(9'd3, 9'd3, 9'd1, 16'd0, 1'b0);
        wait_done(d0, 500, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL readback_done_wait: got no done want done"); end
        tick();
        n_cmp++; if (en_cnt - e0 != (RB ? 4 : 3)) begin n_fail++; $display("FAIL readback_en_count: got %0d want %0d", en_cnt - e0, RB ? 4 : 3); end
        n_cmp++; if (sq.size() <= s0 || sq[s0] !== (RB ? 9'h1FF : 9'd3)) begin
            n_fail++; $display("FAIL readback_step_delay: got %h want %h", (sq.size() > s0) ? sq[s0] : 9'h0, RB ? 9'h1FF : 9'd3);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int e0, d0;
        d0 = done_cnt;
        start_sweep(9'd0, 9'd8, 9'd1, 16'd20, 1'b0);
        repeat (12) tick();
        rst = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_cmp++; if (M_NATIVE_EN !== 1'b0) begin n_fail++; $display("FAIL midrst_en: got %b want 0", M_NATIVE_EN); end
        rst = 1'b0;
        e0 = en_cnt;
        repeat (30) tick();
        n_cmp++; if (en_cnt != e0) begin n_fail++; $display("FAIL midrst_no_vtc_on: got %0d want 0", en_cnt - e0); end
        n_cmp++; if (done_cnt != d0) begin n_fail++; $display("FAIL midrst_no_done: got %0d want 0", done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_single_step();
        test_bad_cfg();
        test_timeout();
        test_abort();
        test_readback();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/delay_sweep_ctrl.md
DELAY_SWEEP_CTRL -- requirements
Module: delay_sweep_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NATIVE_ADDR_WDITH, 2, native port address width.
- NATIVE_DATA_WIDTH, 32, native port data width.
- DELAY_WIDTH, 9, delay tap value width.
- DWELL_WIDTH, 16, dwell counter width.
- TIMEOUT_CYCLES, 255, maximum cycles to wait for M_NATIVE_READY.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- NATIVE_CLK, in, 1, the only clock.
- rst, in, 1, synchronous active-high reset.
- sweep_start, in, 1, one-cycle request to start a sweep.
- sweep_abort, in, 1, one-cycle request to end the sweep early.
- cfg_start, in, DELAY_WIDTH, first delay value.
- cfg_stop, in, DELAY_WIDTH, last delay value.
- cfg_step, in, DELAY_WIDTH, delay increment.
- cfg_dwell, in, DWELL_WIDTH, settle cycles per step.
- busy, out, 1, sweep in progress.
- done, out, 1, one-cycle pulse when the sweep ends.
- error, out, 1, sticky until the next accepted sweep_start.
- step_valid, out, 1, one-cycle pulse per settled step.
- step_delay, out, DELAY_WIDTH, delay value reported for the step.
- M_NATIVE_EN, out, 1, native transaction strobe.
- M_NATIVE_WR, out, 1, 1 = write, 0 = read.
- M_NATIVE_ADDR, out, NATIVE_ADDR_WDITH, 0 = delay, 1 = EN_VTC.
- M_NATIVE_DATA_IN, out, NATIVE_DATA_WIDTH, write data.
- M_NATIVE_DATA_OUT, in, NATIVE_DATA_WIDTH, read data.
- M_NATIVE_READY, in, 1, target completion.

REQ-003 There SHALL be one clock (NATIVE_CLK); reset SHALL be synchronous and active-high (rst).

Function
REQ-004 The block SHALL have these states: IDLE, VTC_OFF, SET, DWELL, READ, NEXT, VTC_ON, DONE, plus a shared WAIT sub-state used after every transaction.
REQ-005 A transaction SHALL be:
- M_NATIVE_EN high for exactly 1 cycle, with WR, ADDR and DATA_IN held valid from the EN cycle until completion.
- M_NATIVE_READY is ignored in the EN cycle and in the cycle after it.
- Completion is the first later cycle with M_NATIVE_READY high.
REQ-006 While waiting, a counter SHALL count cycles after EN; if it reaches TIMEOUT_CYCLES without READY, the block SHALL set error and go to DONE, issuing no further transactions.
REQ-007 In IDLE, sweep_start SHALL:
- latch all cfg_* values;
- clear error;
- raise busy the next cycle;
- go to VTC_OFF.
sweep_start SHALL be ignored while busy.
REQ-008 If cfg_start > cfg_stop at latch, the block SHALL go straight to DONE with error=1 and issue no transactions.
REQ-009 A latched cfg_step of 0 SHALL be treated as 1.
REQ-010 The state sequence SHALL be:
- VTC_OFF writes addr 1, data 0.
- SET writes addr 0, data = current delay, zero-extended.
- DWELL waits cfg_dwell cycles; 0 means skip.
- READ (see Configuration).
- step_valid pulses for 1 cycle in NEXT.
REQ-011 In NEXT, if current delay + step > cfg_stop (computed at DELAY_WIDTH+1 bits, no wrap), the block SHALL go to VTC_ON; otherwise it SHALL add step to the current delay and go to SET.
REQ-012 VTC_ON SHALL write addr 1, data 1, then go to DONE; DONE SHALL pulse done for 1 cycle, drop busy and return to IDLE.
REQ-013 A sweep_abort seen in any busy state SHALL be recorded; the in-flight transaction SHALL complete, then the block SHALL go to VTC_ON, with no further step_valid pulses.
REQ-014 If sweep_start and sweep_abort arrive in the same IDLE cycle, start SHALL win and the abort SHALL be ignored.
REQ-015 The last stepped value SHALL be ≤ cfg_stop; cfg_start == cfg_stop SHALL give exactly one step.

Reset
REQ-016 On rst the block SHALL:
- go to IDLE;
- drive busy, done, error, step_valid and M_NATIVE_EN to 0;
- drive M_NATIVE_WR, M_NATIVE_ADDR, M_NATIVE_DATA_IN and step_delay to 0;
- clear all counters and latched configuration.
REQ-017 A reset mid-sweep SHALL abandon the sweep immediately, with no VTC_ON write and no done pulse.

Configuration
REQ-018 Macro SWEEP_READBACK_EN SHALL select the READ behaviour:
- Defined: READ issues a read of addr 0, and step_delay = M_NATIVE_DATA_OUT[DELAY_WIDTH-1:0] captured in the completion cycle.
- Undefined: the READ state is bypassed and step_delay = the commanded delay.

Verification
REQ-019 Bench with a target model returning READY 3 cycles after EN; start=10, stop=20, step=5, dwell=4 -> writes in order: a1=0, a0=10, a0=15, a0=20, a1=1; 3 step_valid pulses with step_delay 10, 15, 20; 1 done pulse.
REQ-020 start=7, stop=7, step=0 -> exactly 1 step (delay 7), done pulse, error=0.
REQ-021 start=20, stop=10 -> done within 3 cycles, error=1, M_NATIVE_EN never high.
REQ-022 READY held low -> error=1 after TIMEOUT_CYCLES, done pulse, no further EN.
REQ-023 sweep_abort during DWELL of the second step -> no further step_valid; next transaction is the a1=1 write; then done.
REQ-024 With SWEEP_READBACK_EN defined and the model returning 0x1FF on read -> step_delay = 0x1FF; with it undefined -> step_delay = the commanded value.
